piso_frame_serializer: RTL and testbench



---
 rtl/piso_frame_serializer_pkg.sv | 24 ++
 rtl/piso_frame_serializer_if.sv | 37 +++
 rtl/piso_frame_serializer_shift_core.sv | 57 +++++
 rtl/piso_frame_serializer.sv | 114 +++++++++++
 tb/tb_piso_frame_serializer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_frame_serializer_pkg.sv
// rtl/piso_frame_serializer_pkg.sv - shared types, direction constants and width helper for the frame serializer
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam bit DIR_MSB_FIRST = 1'b1;
    localparam bit DIR_LSB_FIRST = 1'b0;

    // Bits needed to index 0..value-1; never less than one so a counter always exists.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/piso_frame_serializer_if.sv
// rtl/piso_frame_serializer_if.sv - parallel input and serial output handshake bundle
interface piso_frame_serializer_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;

    modport master (
        output in_data,
        output in_valid,
        output ser_ready,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_first,
        input  ser_last
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  ser_ready,
        output in_ready,
        output ser_out,
        output ser_valid,
        output ser_first,
        output ser_last
    );

endinterface

// File: rtl/piso_frame_serializer_shift_core.sv
// rtl/piso_frame_serializer_shift_core.sv - shift register with bit counter and registered frame flags
module piso_shift_core
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = DIR_MSB_FIRST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             bit_out,
    output logic             first,
    output logic             last
);

    localparam int CW = clog2(WIDTH);

    logic [WIDTH-1:0] shifter;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt;

    // The output end is a flop bit, so bit_out needs no extra register stage.
    generate
        if (MSB_FIRST == DIR_LSB_FIRST) begin : g_lsb
            assign shifted = {1'b0, shifter[WIDTH-1:1]};
            assign bit_out = shifter[0];
        end else begin : g_msb
            assign shifted = {shifter[WIDTH-2:0], 1'b0};
            assign bit_out = shifter[WIDTH-1];
        end
    endgenerate

    // Load wins over shift: a frame boundary reload replaces the last-bit shift.
    // first/last are registered one step ahead from bit_cnt so they flip with the bit they tag.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shifter <= '0;
            bit_cnt <= '0;
            first   <= 1'b0;
            last    <= 1'b0;
        end else if (load) begin
            shifter <= load_data;
            bit_cnt <= '0;
            first   <= 1'b1;
            last    <= 1'b0;
        end else if (shift) begin
            shifter <= shifted;
            bit_cnt <= bit_cnt + 1'b1;
            first   <= 1'b0;
            last    <= (bit_cnt == CW'(WIDTH - 2));
        end
    end

endmodule

// File: rtl/piso_frame_serializer.sv
// rtl/piso_frame_serializer.sv - parallel word to framed serial stream with one-word hold buffer
module piso_frame_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = DIR_MSB_FIRST,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    piso_frame_serializer_if.slave bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       words_sent
);

    state_t           state;
    logic             ser_valid_q;
    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;

    logic             accept;
    logic             consume;
    logic             frame_end;
    logic             core_last;
    logic             core_load;
    logic             core_shift;
    logic             core_clear;
    logic [WIDTH-1:0] core_data;

    assign bus.in_ready  = !hold_valid;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_last  = core_last;

    assign accept    = bus.in_valid && !hold_valid;
    assign consume   = ser_valid_q && bus.ser_ready;
    assign frame_end = consume && core_last;

    // Shifter control: at a frame end the held word has priority, then a same-cycle
    // accept bypasses straight in, otherwise the shifter is cleared and the line idles.
    always_comb begin
        core_load  = 1'b0;
        core_clear = 1'b0;
        core_shift = consume;
        core_data  = bus.in_data;
        if (state == IDLE) begin
            core_load = accept;
        end else if (frame_end) begin
            if (hold_valid) begin
                core_load = 1'b1;
                core_data = hold_data;
            end else if (accept) begin
                core_load = 1'b1;
            end else begin
                core_clear = 1'b1;
            end
        end
    end

    piso_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .clear     (core_clear),
        .load      (core_load),
        .shift     (core_shift),
        .load_data (core_data),
        .bit_out   (bus.ser_out),
        .first     (bus.ser_first),
        .last      (core_last)
    );

    // Frame FSM, hold buffer and frame counter; busy and ser_valid are registered alongside state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ser_valid_q <= 1'b0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            busy        <= 1'b0;
            words_sent  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= SHIFT;
                        ser_valid_q <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (frame_end) begin
                        words_sent <= words_sent + 1'b1;
                        if (hold_valid) begin
                            hold_valid <= 1'b0;
                        end else if (!accept) begin
                            state       <= IDLE;
                            ser_valid_q <= 1'b0;
                            busy        <= 1'b0;
                        end
                    end else if (accept) begin
                        hold_valid <= 1'b1;
                        hold_data  <= bus.in_data;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_frame_serializer.sv
// tb/tb_piso_frame_serializer.sv - self-checking bench for the frame serializer in three configurations
module tb_piso_frame_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_data;
    logic       in_valid;
    logic       ser_ready;
    logic       chk_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] act_v, exp_v, act_o, exp_o, act_f, exp_f, act_l, exp_l;
    logic [2:0] act_r, exp_r, act_b, exp_b;
    logic [7:0] act_ws [3];
    logic [7:0] exp_ws [3];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // lane 0: MSB first, 8-bit counter; lane 1: LSB first; lane 2: MSB first, 2-bit counter
    for (genvar g = 0; g < 3; g++) begin : lane
        localparam bit MSB = (g != 1);
        localparam int CW  = (g == 2) ? 2 : 8;

        piso_frame_serializer_if #(.WIDTH(4)) bus ();
        logic          busy;
        logic [CW-1:0] ws;

        piso_frame_serializer #(
            .WIDTH     (4),
            .MSB_FIRST (MSB),
            .CNT_W     (CW)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .bus        (bus),
            .busy       (busy),
            .words_sent (ws)
        );

        assign bus.in_data   = in_data;
        assign bus.in_valid  = in_valid;
        assign bus.ser_ready = ser_ready;

        assign act_v[g]  = bus.ser_valid;
        assign act_o[g]  = bus.ser_out;
        assign act_f[g]  = bus.ser_first;
        assign act_l[g]  = bus.ser_last;
        assign act_r[g]  = bus.in_ready;
        assign act_b[g]  = busy;
        assign act_ws[g] = 8'(ws);

        // Model: queue of accepted-but-unfinished words, index of the bit on the line, frame count.
        logic [3:0] mq [$];
        int         midx = 0;
        int         mcnt = 0;
        logic       m_valid = 1'b0, m_out = 1'b0, m_first = 1'b0, m_last = 1'b0;
        logic       m_ready = 1'b1, m_busy = 1'b0;
        logic [7:0] m_ws = 8'd0;

        assign exp_v[g]  = m_valid;
        assign exp_o[g]  = m_out;
        assign exp_f[g]  = m_first;
        assign exp_l[g]  = m_last;
        assign exp_r[g]  = m_ready;
        assign exp_b[g]  = m_busy;
        assign exp_ws[g] = m_ws;

        // Model update on each clock from the bench-driven inputs only.
        always @(posedge clk) begin : model
            logic       acc;
            logic       con;
            logic [3:0] w;
            if (reset) begin
                mq.delete();
                midx = 0;
                mcnt = 0;
            end else begin
                acc = in_valid && (mq.size() < 2);
                con = (mq.size() > 0) && ser_ready;
                if (con) begin
                    midx++;
                    if (midx == 4) begin
                        void'(mq.pop_front());
                        midx = 0;
                        mcnt++;
                    end
                end
                if (acc) mq.push_back(in_data);
            end
            m_valid = (mq.size() > 0);
            m_ready = (mq.size() < 2);
            m_busy  = m_valid;
            w       = m_valid ? mq[0] : 4'b0000;
            m_out   = MSB ? w[3 - midx] : w[midx];
            m_first = (midx == 0);
            m_last  = (midx == 3);
            m_ws    = 8'(mcnt % (1 << CW));
        end
    end

    // Every-cycle comparison of all three lanes against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("lane%0d ser_valid", g), 8'(act_v[g]), 8'(exp_v[g]));
                if (exp_v[g]) begin
                    chk($sformatf("lane%0d ser_out", g), 8'(act_o[g]), 8'(exp_o[g]));
                    chk($sformatf("lane%0d ser_first", g), 8'(act_f[g]), 8'(exp_f[g]));
                    chk($sformatf("lane%0d ser_last", g), 8'(act_l[g]), 8'(exp_l[g]));
                end
                chk($sformatf("lane%0d in_ready", g), 8'(act_r[g]), 8'(exp_r[g]));
                chk($sformatf("lane%0d busy", g), 8'(act_b[g]), 8'(exp_b[g]));
                chk($sformatf("lane%0d words_sent", g), act_ws[g], exp_ws[g]);
            end
        end
    end

    initial begin
        logic [7:0] bits, firsts, lasts, vals, bits1;
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        ser_ready = 1'b1;
        chk_en    = 1'b0;
        step();
        step();
        reset  = 1'b0;
        chk_en = 1'b1;

        chk("reset ser_valid", 8'(act_v[0]), 8'd0);
        chk("reset ser_out", 8'(act_o[0]), 8'd0);
        chk("reset ser_first", 8'(act_f[0]), 8'd0);
        chk("reset ser_last", 8'(act_l[0]), 8'd0);
        chk("reset busy", 8'(act_b[0]), 8'd0);
        chk("reset in_ready", 8'(act_r[0]), 8'd1);
        chk("reset words_sent", act_ws[0], 8'd0);

        // single word 1010
        in_valid = 1'b1;
        in_data  = 4'b1010;
        bits = '0; firsts = '0; lasts = '0; vals = '0; bits1 = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid = 1'b0;
            bits   = {bits[6:0], act_o[0]};
            bits1  = {bits1[6:0], act_o[1]};
            firsts = {firsts[6:0], act_f[0]};
            lasts  = {lasts[6:0], act_l[0]};
            vals   = {vals[6:0], act_v[0]};
        end
        chk("single bits msb", bits, 8'b0000_1010);
        chk("single bits lsb", bits1, 8'b0000_0101);
        chk("single first", firsts, 8'b0000_1000);
        chk("single last", lasts, 8'b0000_0001);
        chk("single valid", vals, 8'b0000_1111);
        step();
        chk("single end valid", 8'(act_v[0]), 8'd0);
        chk("single words_sent", act_ws[0], 8'd1);
        chk("single words_sent wrap lane", act_ws[2], 8'd1);

        // back-to-back 1010 then 0011
        in_valid = 1'b1;
        in_data  = 4'b1010;
        bits = '0; vals = '0;
        step();
        bits = {bits[6:0], act_o[0]};
        vals = {vals[6:0], act_v[0]};
        in_data = 4'b0011;
        step();
        bits = {bits[6:0], act_o[0]};
        vals = {vals[6:0], act_v[0]};
        chk("b2b hold in_ready", 8'(act_r[0]), 8'd0);
        in_valid = 1'b0;
        for (int i = 2; i < 8; i++) begin
            step();
            bits = {bits[6:0], act_o[0]};
            vals = {vals[6:0], act_v[0]};
            if (i == 4) chk("b2b in_ready after transfer", 8'(act_r[0]), 8'd1);
        end
        chk("b2b bits", bits, 8'b1010_0011);
        chk("b2b contiguous valid", vals, 8'hFF);
        step();
        chk("b2b end valid", 8'(act_v[0]), 8'd0);
        chk("b2b words_sent", act_ws[0], 8'd3);
        chk("b2b words_sent wrap lane", act_ws[2], 8'd3);

        // stall 1001 with three stalled cycles on the first bit
        in_valid = 1'b1;
        in_data  = 4'b1001;
        step();
        in_valid  = 1'b0;
        ser_ready = 1'b0;
        bits   = {7'd0, act_o[0]};
        firsts = {7'd0, act_f[0]};
        lasts  = {7'd0, act_l[0]};
        vals   = {7'd0, act_v[0]};
        for (int i = 1; i < 7; i++) begin
            step();
            bits   = {bits[6:0], act_o[0]};
            firsts = {firsts[6:0], act_f[0]};
            lasts  = {lasts[6:0], act_l[0]};
            vals   = {vals[6:0], act_v[0]};
            if (i == 3) ser_ready = 1'b1;
        end
        chk("stall bits", bits, 8'b0111_1001);
        chk("stall first", firsts, 8'b0111_1000);
        chk("stall last", lasts, 8'b0000_0001);
        chk("stall valid 7 cycles", vals, 8'b0111_1111);
        step();
        chk("stall end valid", 8'(act_v[0]), 8'd0);
        chk("stall words_sent wrap lane", act_ws[2], 8'd0);

        // hold full: three words offered with the sink stalled
        ser_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'b0110;
        step();
        chk("holdfull first in_ready", 8'(act_r[0]), 8'd1);
        in_data = 4'b0101;
        step();
        chk("holdfull second in_ready", 8'(act_r[0]), 8'd0);
        in_data = 4'b1111;
        step();
        chk("holdfull third refused a", 8'(act_r[0]), 8'd0);
        step();
        chk("holdfull third refused b", 8'(act_r[0]), 8'd0);
        ser_ready = 1'b1;
        n = 0;
        while (act_r[0] == 1'b0 && n < 10) begin
            step();
            n++;
        end
        chk("holdfull cycles to ready", 8'(n), 8'd4);
        step();
        in_valid = 1'b0;
        n = 0;
        while (act_v[0] && n < 20) begin
            step();
            n++;
        end
        chk("holdfull drained", 8'(act_v[0]), 8'd0);
        chk("holdfull words_sent", act_ws[0], 8'd7);
        chk("holdfull words_sent wrap lane", act_ws[2], 8'd3);

        // LSB-first full frame 0011
        in_valid = 1'b1;
        in_data  = 4'b0011;
        bits1 = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid = 1'b0;
            bits1 = {bits1[6:0], act_o[1]};
        end
        chk("lsb bits", bits1, 8'b0000_1100);
        step();
        chk("lsb words_sent", act_ws[1], 8'd8);
        chk("lsb words_sent wrap lane", act_ws[2], 8'd0);

        // reset during the second bit of a frame
        in_valid = 1'b1;
        in_data  = 4'b0011;
        step();
        in_valid = 1'b0;
        step();
        chk("midreset second bit", 8'(act_o[1]), 8'd1);
        reset = 1'b1;
        step();
        chk("midreset ser_valid", 8'(act_v[1]), 8'd0);
        chk("midreset ser_out", 8'(act_o[1]), 8'd0);
        chk("midreset ser_first", 8'(act_f[1]), 8'd0);
        chk("midreset ser_last", 8'(act_l[1]), 8'd0);
        chk("midreset busy", 8'(act_b[1]), 8'd0);
        chk("midreset in_ready", 8'(act_r[1]), 8'd1);
        chk("midreset words_sent", act_ws[1], 8'd0);
        reset = 1'b0;
        step();
        step();
        chk("post reset idle", 8'(act_v[1]), 8'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
